// File: rtl/fpjh_frame_checker_pkg.sv
// fpjh_frame_checker_pkg: seed default, keep codes, keep helpers and FSM states shared by the fpjh benches
package fpjh_frame_checker_pkg;
    localparam logic [31:0] FPJH_SEED = 32'h1234_5678;
    localparam logic [3:0] KEEP_4 = 4'hF;
    localparam logic [3:0] KEEP_3 = 4'hE;
    localparam logic [3:0] KEEP_2 = 4'hC;
    localparam logic [3:0] KEEP_1 = 4'h8;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BODY = 2'd1, S_FLUSH = 2'd2} state_t;
    function automatic logic [2:0] keep_bytes(input logic [3:0] k);
        return k == KEEP_4 ? 3'd4 : k == KEEP_3 ? 3'd3 : k == KEEP_2 ? 3'd2 : k == KEEP_1 ? 3'd1 : 3'd0;
    endfunction
    function automatic logic [31:0] keep_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction
endpackage

// File: rtl/fpjh_lfsr_ready.sv
// fpjh_lfsr_ready: registered tready, constant or driven by a 16-bit Fibonacci LFSR (taps 16,14,13,11)
module fpjh_lfsr_ready #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int READY_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    output logic ready
);
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // ready tracks lfsr[0]|lfsr[1] of the register it is loaded alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            ready <= 1'b0;
        end else begin
            lfsr  <= lfsr_nxt;
            ready <= READY_MODE == 0 ? 1'b1 : (lfsr_nxt[0] | lfsr_nxt[1]);
        end
    end
endmodule

// File: rtl/fpjh_frame_checker.sv
// fpjh_frame_checker: AXIS sink checking SEED+k beat data, frame length and tkeep legality
module fpjh_frame_checker
    import fpjh_frame_checker_pkg::*;
#(
    parameter logic [31:0] SEED = FPJH_SEED,
    parameter int MAX_BEATS = 1024,
    parameter int READY_MODE = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_axis_tdata,
    input  logic [3:0]  i_axis_tkeep,
    input  logic        i_axis_tvalid,
    input  logic        i_axis_tlast,
    output logic        i_axis_tready,
    input  logic [31:0] i_length,
    input  logic        i_clear,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [31:0] o_frame_cnt,
    output logic [31:0] o_good_cnt,
    output logic [15:0] o_err_data_cnt,
    output logic [15:0] o_err_len_cnt,
    output logic [15:0] o_err_keep_cnt,
    output logic [3:0]  o_err_sticky,
    output logic        o_timeout
);
    localparam int BW = $clog2(MAX_BEATS + 1);
    state_t state;
    logic [BW-1:0] beat_idx;
    logic [31:0] byte_acc;
    logic f_data, f_len, f_keep;
    logic [31:0] idle_cnt;
    logic started;
    logic hs, chk, last_hs, to_flush, timeout_hit;
    logic b_data, b_keep, fin_data, fin_len, fin_keep, fin_ok;
    logic [2:0] nbytes;
    logic [31:0] acc_sum;

    fpjh_lfsr_ready #(.LFSR_SEED(LFSR_SEED), .READY_MODE(READY_MODE)) u_ready (
        .clk  (clk),
        .rst  (rst),
        .ready(i_axis_tready)
    );

    // beat_idx, byte_acc and the frame flags are zero whenever the FSM sits in S_IDLE
    assign hs          = i_axis_tvalid & i_axis_tready;
    assign chk         = hs & (state != S_FLUSH);
    assign last_hs     = hs & i_axis_tlast;
    assign nbytes      = keep_bytes(i_axis_tkeep);
    assign b_data      = chk & (((i_axis_tdata ^ (SEED + 32'(beat_idx))) & keep_mask(i_axis_tkeep)) != '0);
    assign b_keep      = chk & ((nbytes == 3'd0) | (~i_axis_tlast & (i_axis_tkeep != KEEP_4)));
    assign acc_sum     = byte_acc + 32'(nbytes);
    assign to_flush    = chk & ~i_axis_tlast & (32'(beat_idx) + 32'd1 == 32'(MAX_BEATS));
    assign fin_data    = f_data | b_data;
    assign fin_keep    = f_keep | b_keep;
    assign fin_len     = f_len | (acc_sum != i_length);
    assign fin_ok      = ~(fin_data | fin_len | fin_keep);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt >= 32'(TIMEOUT_CYC));
    assign o_timeout   = o_err_sticky[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            beat_idx       <= '0;
            byte_acc       <= '0;
            f_data         <= 1'b0;
            f_len          <= 1'b0;
            f_keep         <= 1'b0;
            idle_cnt       <= '0;
            started        <= 1'b0;
            o_frame_done   <= 1'b0;
            o_frame_ok     <= 1'b0;
            o_frame_cnt    <= '0;
            o_good_cnt     <= '0;
            o_err_data_cnt <= '0;
            o_err_len_cnt  <= '0;
            o_err_keep_cnt <= '0;
            o_err_sticky   <= '0;
        end else begin
            o_frame_done <= last_hs;
            if (last_hs) o_frame_ok <= fin_ok;
            if (last_hs) begin
                state    <= S_IDLE;
                beat_idx <= '0;
                byte_acc <= '0;
                f_data   <= 1'b0;
                f_len    <= 1'b0;
                f_keep   <= 1'b0;
            end else if (chk) begin
                state    <= to_flush ? S_FLUSH : S_BODY;
                beat_idx <= beat_idx + BW'(1);
                byte_acc <= acc_sum;
                f_data   <= fin_data;
                f_keep   <= fin_keep;
                f_len    <= f_len | to_flush;
            end
            if (i_clear) begin
                idle_cnt       <= '0;
                started        <= 1'b0;
                o_frame_cnt    <= '0;
                o_good_cnt     <= '0;
                o_err_data_cnt <= '0;
                o_err_len_cnt  <= '0;
                o_err_keep_cnt <= '0;
                o_err_sticky   <= '0;
            end else begin
                started        <= started | hs;
                idle_cnt       <= hs ? 32'd0 : idle_cnt + 32'(started & (idle_cnt != '1));
                o_frame_cnt    <= o_frame_cnt + 32'(last_hs);
                o_good_cnt     <= o_good_cnt + 32'(last_hs & fin_ok);
                o_err_data_cnt <= o_err_data_cnt + 16'(last_hs & fin_data & (o_err_data_cnt != '1));
                o_err_len_cnt  <= o_err_len_cnt + 16'(last_hs & fin_len & (o_err_len_cnt != '1));
                o_err_keep_cnt <= o_err_keep_cnt + 16'(last_hs & fin_keep & (o_err_keep_cnt != '1));
                o_err_sticky   <= o_err_sticky | {timeout_hit, last_hs & fin_keep, last_hs & fin_len, last_hs & fin_data};
            end
        end
    end
endmodule

// File: tb/tb_fpjh_frame_checker.sv
// tb_fpjh_frame_checker: table-driven frame vectors plus directed backpressure, timeout and clear sequences
module tb_fpjh_frame_checker;
    localparam logic [31:0] SEED = 32'h1234_5678;
    localparam int TMO = 500;

    typedef struct {
        int nb;
        logic [3:0] lk;
        int mid_b;
        logic [3:0] mid_k;
        int bad_a;
        int bad_b;
        logic [31:0] len;
        int gap;
        bit d;
        bit l;
        bit k;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] tdata = '0;
    logic [3:0] tkeep = '0;
    logic tvalid0 = 1'b0, tvalid1 = 1'b0, tlast = 1'b0, clr = 1'b0;
    logic [31:0] length = '0;
    logic rdy0, done0, ok0, tmo0, rdy1, done1, ok1, tmo1;
    logic [31:0] fcnt0, gcnt0, fcnt1, gcnt1;
    logic [15:0] dcnt0, lcnt0, kcnt0, dcnt1, lcnt1, kcnt1;
    logic [3:0] stk0, stk1;

    int n_cmp = 0, n_bad = 0, stalls = 0;
    int exp_f = 0, exp_g = 0, exp_d = 0, exp_l = 0, exp_k = 0;
    logic [3:0] exp_s = '0;
    vec_t tbl[11];

    always #5 clk = ~clk;

    fpjh_frame_checker #(.TIMEOUT_CYC(TMO)) u0 (
        .clk(clk), .rst(rst), .i_axis_tdata(tdata), .i_axis_tkeep(tkeep), .i_axis_tvalid(tvalid0),
        .i_axis_tlast(tlast), .i_axis_tready(rdy0), .i_length(length), .i_clear(clr),
        .o_frame_done(done0), .o_frame_ok(ok0), .o_frame_cnt(fcnt0), .o_good_cnt(gcnt0),
        .o_err_data_cnt(dcnt0), .o_err_len_cnt(lcnt0), .o_err_keep_cnt(kcnt0),
        .o_err_sticky(stk0), .o_timeout(tmo0)
    );

    fpjh_frame_checker #(.READY_MODE(1), .TIMEOUT_CYC(TMO)) u1 (
        .clk(clk), .rst(rst), .i_axis_tdata(tdata), .i_axis_tkeep(tkeep), .i_axis_tvalid(tvalid1),
        .i_axis_tlast(tlast), .i_axis_tready(rdy1), .i_length(length), .i_clear(1'b0),
        .o_frame_done(done1), .o_frame_ok(ok1), .o_frame_cnt(fcnt1), .o_good_cnt(gcnt1),
        .o_err_data_cnt(dcnt1), .o_err_len_cnt(lcnt1), .o_err_keep_cnt(kcnt1),
        .o_err_sticky(stk1), .o_timeout(tmo1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // called at a negedge; returns at a negedge after the done check and the gap
    task automatic send_frame(input bit sel, input int nb, input logic [3:0] lk, input int mid_b,
                              input logic [3:0] mid_k, input int bad_a, input int bad_b,
                              input logic [31:0] len, input int gap);
        for (int b = 0; b < nb; b++) begin
            int w;
            tdata = (b == bad_a || b == bad_b) ? 32'h0 : SEED + 32'(b);
            tkeep = (b == nb - 1) ? lk : (b == mid_b) ? mid_k : 4'hF;
            tlast = (b == nb - 1);
            length = len;
            if (sel) tvalid1 = 1'b1; else tvalid0 = 1'b1;
            w = 0;
            while (!(sel ? rdy1 : rdy0) && w < 1000) begin
                @(negedge clk);
                w++;
                stalls++;
            end
            if (w >= 1000) chk("ready_wait_budget", 32'(w), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        tvalid0 = 1'b0;
        tvalid1 = 1'b0;
        tlast = 1'b0;
        chk("done_one_cycle_after_tlast", 32'(sel ? done1 : done0), 32'd1);
        if (gap > 0) begin
            @(negedge clk);
            chk("done_single_pulse", 32'(sel ? done1 : done0), 32'd0);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    initial begin
        tbl[0]  = '{15, 4'h8, -1, 4'hF, -1, -1, 32'd57, 0, 0, 0, 0};
        tbl[1]  = '{15, 4'h8, -1, 4'hF, -1, -1, 32'd57, 16, 0, 0, 0};
        tbl[2]  = '{15, 4'h8, -1, 4'hF, -1, -1, 32'd57, 16, 0, 0, 0};
        tbl[3]  = '{15, 4'hE, -1, 4'hF, -1, -1, 32'd59, 16, 0, 0, 0};
        tbl[4]  = '{15, 4'hE, -1, 4'hF, -1, -1, 32'd58, 16, 0, 1, 0};
        tbl[5]  = '{15, 4'h8, -1, 4'hF, 5, 6, 32'd57, 16, 1, 0, 0};
        tbl[6]  = '{15, 4'h8, 2, 4'hC, -1, -1, 32'd55, 16, 0, 0, 1};
        tbl[7]  = '{15, 4'h4, -1, 4'hF, -1, -1, 32'd56, 16, 0, 0, 1};
        tbl[8]  = '{1, 4'hF, -1, 4'hF, -1, -1, 32'd4, 16, 0, 0, 0};
        tbl[9]  = '{1028, 4'hF, -1, 4'hF, -1, -1, 32'd4112, 16, 0, 1, 0};
        tbl[10] = '{15, 4'h8, -1, 4'hF, -1, -1, 32'd57, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tready0", 32'(rdy0), 32'd0);
        chk("rst_tready1", 32'(rdy1), 32'd0);
        chk("rst_frame_cnt", fcnt0, 32'd0);
        chk("rst_done_ok_sticky", {26'd0, done0, ok0, stk0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", 32'(rdy0), 32'd1);

        // idle before any frame must not time out
        repeat (TMO + 100) @(negedge clk);
        chk("no_timeout_before_first_frame", 32'(tmo0), 32'd0);

        // backpressured 208-beat frames on the LFSR-ready instance
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b1, 208, 4'h8, -1, 4'hF, -1, -1, 32'd829, 3);
            chk("bp_frame_ok", 32'(ok1), 32'd1);
        end
        chk("bp_frame_cnt", fcnt1, 32'd2);
        chk("bp_good_cnt", gcnt1, 32'd2);
        chk("bp_err_data", 32'(dcnt1), 32'd0);
        chk("bp_sticky", 32'(stk1), 32'd0);
        chk("bp_stalls_seen", 32'(stalls > 0), 32'd1);

        foreach (tbl[i]) begin
            send_frame(1'b0, tbl[i].nb, tbl[i].lk, tbl[i].mid_b, tbl[i].mid_k, tbl[i].bad_a,
                       tbl[i].bad_b, tbl[i].len, tbl[i].gap);
            exp_f++;
            exp_g += (tbl[i].d | tbl[i].l | tbl[i].k) ? 0 : 1;
            exp_d += int'(tbl[i].d);
            exp_l += int'(tbl[i].l);
            exp_k += int'(tbl[i].k);
            exp_s |= {1'b0, tbl[i].k, tbl[i].l, tbl[i].d};
            chk($sformatf("v%0d_frame_ok", i), 32'(ok0), 32'(!(tbl[i].d | tbl[i].l | tbl[i].k)));
            chk($sformatf("v%0d_frame_cnt", i), fcnt0, 32'(exp_f));
            chk($sformatf("v%0d_good_cnt", i), gcnt0, 32'(exp_g));
            chk($sformatf("v%0d_err_data", i), 32'(dcnt0), 32'(exp_d));
            chk($sformatf("v%0d_err_len", i), 32'(lcnt0), 32'(exp_l));
            chk($sformatf("v%0d_err_keep", i), 32'(kcnt0), 32'(exp_k));
            chk($sformatf("v%0d_sticky", i), 32'(stk0), 32'(exp_s));
        end

        // last accepted beat was one posedge before this negedge
        repeat (TMO - 5) @(negedge clk);
        chk("timeout_not_yet", 32'(tmo0), 32'd0);
        repeat (10) @(negedge clk);
        chk("timeout_set", 32'(tmo0), 32'd1);
        chk("timeout_sticky", 32'(stk0), 32'hF);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_frame_cnt", fcnt0, 32'd0);
        chk("clr_good_cnt", gcnt0, 32'd0);
        chk("clr_err_cnts", {dcnt0, lcnt0 | kcnt0}, 32'd0);
        chk("clr_sticky_timeout", {27'd0, tmo0, stk0}, 32'd0);
        repeat (TMO + 10) @(negedge clk);
        chk("no_timeout_after_clear", 32'(tmo0), 32'd0);

        send_frame(1'b0, 15, 4'h8, -1, 4'hF, -1, -1, 32'd57, 2);
        chk("post_clear_frame_ok", 32'(ok0), 32'd1);
        chk("post_clear_frame_cnt", fcnt0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
